axis_fifo: RTL and testbench
============================

Name: axis_fifo

Overview:
- Synchronous single-clock FIFO with AXI4-Stream-style valid/ready slave input and master output.
- Used as an elastic buffer between streaming blocks; instances chain directly, master of one feeding slave of the next.
- Carries tdata only; no tlast, tkeep or tuser.

Parameters:
- WIDTH, default 32: data width in bits; any value >= 1.
- DEPTH, default 16: storage entries; power of 2, >= 2.
- ADDR_WIDTH, default $clog2(DEPTH): pointer width; derived, must not be overridden.

Ports:
- aclk  in  1  clock; all state updates on rising edge.
- areset  in  1  asynchronous, active-high reset (aclk/areset naming per codebase AXI convention; polarity and asynchrony fixed).
- s_axis_tdata  in  WIDTH  input data.
- s_axis_tvalid  in  1  upstream has data.
- s_axis_tready  out  1  FIFO can accept a word.
- m_axis_tdata  out  WIDTH  head-of-FIFO data.
- m_axis_tvalid  out  1  head word is valid.
- m_axis_tready  in  1  downstream accepts the word.

Behaviour:
- Write handshake: s_axis_tvalid & s_axis_tready at a rising edge stores s_axis_tdata.
- Read handshake: m_axis_tvalid & m_axis_tready at a rising edge pops the head word.
- Storage: DEPTH-entry memory, write and read pointers of ADDR_WIDTH+1 bits (extra wrap bit).
  - empty = pointers equal.
  - full = low bits equal, wrap bits differ.
  - Pointers wrap modulo 2*DEPTH naturally.
- Output flags:
  - s_axis_tready = !full (registered or derived from registered pointers only).
  - m_axis_tvalid = !empty.
  - Neither flag depends combinationally on the other side's valid/ready, so chained instances have no combinational loop.
- m_axis_tdata = mem[rd_ptr] (first-word fall-through). Holds stable while m_axis_tvalid=1 and m_axis_tready=0. Undefined-but-stable when empty; implemented as last memory contents, not X.
- Latency: word written at edge N gives m_axis_tvalid=1 after edge N (visible in cycle N+1). No bypass path; an empty FIFO never presents input data in the same cycle.
- Throughput: one write and one read per cycle sustained.
- Simultaneous write and read, neither full nor empty: both occur; occupancy unchanged.
- Full: s_axis_tready=0, so no write. A same-cycle read frees a slot; s_axis_tready rises the following cycle.
- Empty: m_axis_tvalid=0, so no read. A same-cycle write makes tvalid=1 the following cycle.
- Ordering: strict FIFO; DEPTH words are accepted from empty before s_axis_tready drops.
- Reset (asynchronous assert, synchronous release internally ok):
  - Pointers cleared; m_axis_tvalid=0.
  - s_axis_tready=0 while areset=1; s_axis_tready=1 on the first cycle after release.
  - Memory contents not cleared.
  - Reset mid-operation discards all stored words immediately.

Optional Feature:
- Macro AXIS_FIFO_COUNT_EN.
- Defined: adds output port occupancy [ADDR_WIDTH:0] = wr_ptr - rd_ptr, range 0..DEPTH.
  - Updates on the same edges as the pointers.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then fill: areset pulse, m_axis_tready=0, drive 1,2,3,... with tvalid=1 -> exactly 16 handshakes (data 1..16), s_axis_tready=0 from the cycle after the 16th, m_axis_tvalid=1, m_axis_tdata=1.
- Chain of two instances, downstream tready=0, fill -> 32 words accepted (1..32) before the first stage's tready drops. Then set tready=1 -> outputs 1..32 in order, one per cycle, then m_axis_tvalid falls.
- Simultaneous read/write at half full (8 words), 20 cycles of both handshakes -> occupancy stays 8, output sequence continuous, no loss or duplication.
- Full with read: full FIFO, one pop of word 1 -> s_axis_tready=1 next cycle; a write of 17 then completes; drain yields 2..17.
- Backpressure: random m_axis_tready toggling -> m_axis_tdata stable whenever tvalid=1 and tready=0; pop from empty never occurs.
- Mid-operation reset: areset asserted with 5 words stored -> m_axis_tvalid=0 immediately (asynchronous); after release the FIFO is empty, and writing 0xA5 yields 0xA5 as the next output.

Source files
------------

// File: rtl/axis_fifo.sv
// axis_fifo: single-clock AXI4-Stream elastic FIFO, first-word fall-through; define AXIS_FIFO_COUNT_EN to add the occupancy output
module axis_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready
`ifdef AXIS_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0] occupancy
`endif
);
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                s_ready_q, s_ready_d;
  logic                wr_en, rd_en;
  // next pointers and next ready; ready is precomputed so it is a plain flop output
  always_comb begin
    wr_en     = s_axis_tvalid & s_ready_q;
    rd_en     = m_axis_tvalid & m_axis_tready;
    wr_ptr_d  = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
    rd_ptr_d  = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    s_ready_d = !((wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                  (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]));
  end
  // pointer and ready state; ready stays low through reset and rises on the first edge after release
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= s_ready_d;
    end
  end
  // storage is never cleared, so the output shows stale contents rather than X when empty
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
  end
  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = wr_ptr_q != rd_ptr_q;
  assign m_axis_tdata  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
`ifdef AXIS_FIFO_COUNT_EN
  assign occupancy = wr_ptr_q - rd_ptr_q;
`endif
endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: randomized checks of axis_fifo against a queue model
module tb_axis_fifo;
  localparam int W = 32;
  localparam int D = 16;
  logic         aclk = 1'b0;
  logic         areset = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [W-1:0] c_sdata = '0, c_mid_data, c_mdata;
  logic         c_svalid = 1'b0, c_sready, c_mid_valid, c_mid_ready, c_mvalid;
  logic         c_mready = 1'b0;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] q[$];
  bit           rdy_m = 1'b0;
`ifdef AXIS_FIFO_COUNT_EN
  logic [$clog2(D):0] occ, occ0, occ1;
`endif
  always #5 aclk = ~aclk;
  axis_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
`ifdef AXIS_FIFO_COUNT_EN
    , .occupancy(occ)
`endif
  );
  axis_fifo #(.WIDTH(W), .DEPTH(D)) u0 (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(c_sdata), .s_axis_tvalid(c_svalid), .s_axis_tready(c_sready),
    .m_axis_tdata(c_mid_data), .m_axis_tvalid(c_mid_valid), .m_axis_tready(c_mid_ready)
`ifdef AXIS_FIFO_COUNT_EN
    , .occupancy(occ0)
`endif
  );
  axis_fifo #(.WIDTH(W), .DEPTH(D)) u1 (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(c_mid_data), .s_axis_tvalid(c_mid_valid), .s_axis_tready(c_mid_ready),
    .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready)
`ifdef AXIS_FIFO_COUNT_EN
    , .occupancy(occ1)
`endif
  );
  // drive one cycle from a negedge, advance the model at the posedge, return at the next negedge
  task automatic cycle(input bit sv, input logic [W-1:0] d, input bit mr);
    bit acc, pop;
    s_tvalid = sv;
    s_tdata  = d;
    m_tready = mr;
    acc = sv && rdy_m;
    pop = mr && (q.size() > 0);
    @(posedge aclk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    rdy_m = q.size() < D;
    @(negedge aclk);
    s_tvalid = 1'b0;
    m_tready = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge aclk);
    areset = 1'b1;
    q.delete();
    rdy_m = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", s_tready); end
    repeat (2) @(negedge aclk);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_held_tready got=%b exp=0", s_tready); end
    areset = 1'b0;
    @(posedge aclk);
    rdy_m = 1'b1;
    @(negedge aclk);
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL release_tready got=%b exp=1", s_tready); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL release_tvalid got=%b exp=0", m_tvalid); end
  endtask
  task automatic test_fill();
    int hs = 0;
    for (int i = 0; i < 24; i++) begin
      total++; if (s_tready !== rdy_m) begin bad++; $display("FAIL fill_tready cyc=%0d got=%b exp=%b", i, s_tready, rdy_m); end
      if (s_tready === 1'b1) hs++;
      cycle(1'b1, W'(hs + (s_tready === 1'b1 ? 0 : 1)), 1'b0);
    end
    total++; if (hs != D) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", hs, D); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL fill_full_tready got=%b exp=0", s_tready); end
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL fill_tvalid got=%b exp=1", m_tvalid); end
    total++; if (m_tdata !== 32'd1) begin bad++; $display("FAIL fill_head got=%h exp=1", m_tdata); end
  endtask
  task automatic test_full_read();
    cycle(1'b0, '0, 1'b1);
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL fullrd_tready got=%b exp=1", s_tready); end
    cycle(1'b1, 32'd17, 1'b0);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL fullrd_refull got=%b exp=0", s_tready); end
    for (int k = 2; k <= 17; k++) begin
      total++; if (m_tvalid !== 1'b1 || m_tdata !== W'(k)) begin bad++; $display("FAIL drain_word v=%b got=%h exp=%h", m_tvalid, m_tdata, k); end
      cycle(1'b0, '0, 1'b1);
    end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", m_tvalid); end
  endtask
  task automatic test_simultaneous();
    int n = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 20; i++) begin
      total++; if (m_tvalid !== 1'b1 || s_tready !== 1'b1 || m_tdata !== q[0]) begin bad++; $display("FAIL simul cyc=%0d v=%b r=%b got=%h exp=%h", i, m_tvalid, s_tready, m_tdata, q[0]); end
      cycle(1'b1, $urandom, 1'b1);
    end
    for (int i = 0; i < 12; i++) begin
      if (m_tvalid === 1'b1) begin
        n++;
        total++; if (q.size() == 0 || m_tdata !== q[0]) begin bad++; $display("FAIL simul_drain got=%h", m_tdata); end
      end
      cycle(1'b0, '0, 1'b1);
    end
    total++; if (n != 8) begin bad++; $display("FAIL simul_occupancy got=%0d exp=8", n); end
  endtask
  task automatic test_backpressure();
    logic [W-1:0] prev = '0;
    bit hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit sv, mr;
      sv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) == 0);
      total++; if (m_tvalid !== (q.size() != 0)) begin bad++; $display("FAIL bp_tvalid cyc=%0d got=%b exp=%b", i, m_tvalid, q.size() != 0); end
      total++; if (s_tready !== rdy_m) begin bad++; $display("FAIL bp_tready cyc=%0d got=%b exp=%b", i, s_tready, rdy_m); end
      if (q.size() != 0) begin
        total++; if (m_tdata !== q[0]) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, m_tdata, q[0]); end
      end
      if (hold) begin
        total++; if (m_tdata !== prev) begin bad++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", i, m_tdata, prev); end
      end
      hold = (q.size() != 0) && !mr;
      prev = m_tdata;
      cycle(sv, $urandom, mr);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
  endtask
  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0);
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", m_tvalid); end
    #2 areset = 1'b1;
    q.delete();
    rdy_m = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_async got=%b exp=0", m_tvalid); end
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    rdy_m = 1'b1;
    @(negedge aclk);
    total++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin bad++; $display("FAIL midrst_empty v=%b r=%b exp v=0 r=1", m_tvalid, s_tready); end
    cycle(1'b1, 32'hA5, 1'b0);
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5) begin bad++; $display("FAIL midrst_a5 v=%b got=%h exp=a5", m_tvalid, m_tdata); end
    cycle(1'b0, '0, 1'b1);
  endtask
  task automatic test_chain();
    int acc = 0;
    c_mready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      c_svalid = 1'b1;
      c_sdata  = W'(acc + 1);
      if (c_sready === 1'b1) acc++;
      @(negedge aclk);
    end
    c_svalid = 1'b0;
    total++; if (acc != 2 * D) begin bad++; $display("FAIL chain_count got=%0d exp=%0d", acc, 2 * D); end
    total++; if (c_sready !== 1'b0) begin bad++; $display("FAIL chain_tready got=%b exp=0", c_sready); end
    c_mready = 1'b1;
    for (int k = 1; k <= 2 * D; k++) begin
      total++; if (c_mvalid !== 1'b1 || c_mdata !== W'(k)) begin bad++; $display("FAIL chain_out v=%b got=%h exp=%h", c_mvalid, c_mdata, k); end
      @(negedge aclk);
    end
    total++; if (c_mvalid !== 1'b0) begin bad++; $display("FAIL chain_empty got=%b exp=0", c_mvalid); end
    c_mready = 1'b0;
  endtask
  initial begin
    test_reset();
    test_fill();
    test_full_read();
    test_simultaneous();
    test_backpressure();
    test_mid_reset();
    test_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
